// File: rtl/pll_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : pll_ctrl_pkg
// Desc   : Shared state encoding, default parameters and helpers for the
//          PLL lock sequencer.
// Rev    : 1.0  initial release
// ============================================================================
package pll_ctrl_pkg;

    localparam int UNLOCK_CNT_W = 8;

    localparam int c_state_w = 3;
    typedef logic [c_state_w-1:0] state_t;

    localparam logic [2:0] c_st_reset_pll = 3'd0;
    localparam logic [2:0] c_st_wait_lock = 3'd1;
    localparam logic [2:0] c_st_enable    = 3'd2;
    localparam logic [2:0] c_st_run       = 3'd3;
    localparam logic [2:0] c_st_fault     = 3'd4;

    localparam int c_def_rst_cycles   = 16;
    localparam int c_def_lock_filter  = 64;
    localparam int c_def_lock_timeout = 100000;
    localparam int c_def_en_gap       = 8;
    localparam int c_def_num_clk      = 3;
    localparam int c_def_retry_limit  = 7;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pll_lock_sync.sv
`default_nettype none
// ============================================================================
// Module : pll_lock_sync
// Desc   : Generic two-flop single-bit synchronizer, async active-low reset
//          to 0.
// Rev    : 1.0  initial release
// ============================================================================
module pll_lock_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module : pll_lock_sequencer
// Desc   : Drives PLL reset and per-output clock enables, filters lock,
//          staggers enables, gates system reset and recovers from lock loss.
// Rev    : 1.0  initial release
// ============================================================================
module pll_lock_sequencer
    import pll_ctrl_pkg::*;
#(
    parameter int RST_CYCLES   = c_def_rst_cycles,
    parameter int LOCK_FILTER  = c_def_lock_filter,
    parameter int LOCK_TIMEOUT = c_def_lock_timeout,
    parameter int EN_GAP       = c_def_en_gap,
    parameter int NUM_CLK      = c_def_num_clk,
    parameter int RETRY_LIMIT  = c_def_retry_limit
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pll_lock,
    input  logic                    restart_req,
    output logic                    pll_reset,
    output logic [NUM_CLK-1:0]      pll_enclk,
    output logic                    sys_rst_n,
    output logic                    ready,
    output logic                    fault,
    output logic [UNLOCK_CNT_W-1:0] unlock_cnt
);

    localparam int c_cnt_max = max3(RST_CYCLES, LOCK_TIMEOUT, EN_GAP * (NUM_CLK + 1));
    localparam int c_cnt_w   = $clog2(c_cnt_max) + 1;
    localparam int c_retry_w = $clog2(RETRY_LIMIT + 1);

    localparam logic [c_cnt_w-1:0]      c_cnt_one     = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0]      c_rst_last    = c_cnt_w'(RST_CYCLES - 1);
    localparam logic [c_cnt_w-1:0]      c_filt_last   = c_cnt_w'(LOCK_FILTER - 1);
    localparam logic [c_cnt_w-1:0]      c_tmo_last    = c_cnt_w'(LOCK_TIMEOUT - 1);
    localparam logic [c_cnt_w-1:0]      c_en_last     = c_cnt_w'(NUM_CLK * EN_GAP - 1);
    localparam logic [c_retry_w-1:0]    c_retry_one   = c_retry_w'(1);
    localparam logic [c_retry_w-1:0]    c_retry_limit = c_retry_w'(RETRY_LIMIT);
    localparam logic [NUM_CLK-1:0]      c_enclk_first = NUM_CLK'(1);
    localparam logic [UNLOCK_CNT_W-1:0] c_unlock_max  = '1;
    localparam logic [UNLOCK_CNT_W-1:0] c_unlock_one  = UNLOCK_CNT_W'(1);

    state_t                    r_state;
    logic [c_cnt_w-1:0]        r_cnt;
    logic [c_cnt_w-1:0]        r_filt;
    logic [c_retry_w-1:0]      r_retry;
    logic [UNLOCK_CNT_W-1:0]   r_unlock;
    logic                      r_pll_reset;
    logic [NUM_CLK-1:0]        r_enclk;
    logic                      r_sys_rst_n;
    logic                      r_ready;
    logic                      r_fault;

    logic                      w_lock_s;
    logic [c_cnt_w-1:0]        w_cnt_inc;
    logic [c_cnt_w-1:0]        w_filt_inc;
    logic [c_retry_w-1:0]      w_retry_inc;
    logic                      w_filt_done;
    logic                      w_tmo_done;
    logic                      w_lock_lost;
    logic                      w_restart_run;
    logic                      w_teardown;
    logic [NUM_CLK-1:0]        w_en_set;

    pll_lock_sync u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (pll_lock),
        .o_q   (w_lock_s)
    );

    assign w_cnt_inc   = r_cnt + c_cnt_one;
    assign w_filt_inc  = r_filt + c_cnt_one;
    assign w_retry_inc = r_retry + c_retry_one;

    // The filter wins a tie with the timeout by being tested first below.
    assign w_filt_done   = w_lock_s && (r_filt == c_filt_last);
    assign w_tmo_done    = (r_cnt == c_tmo_last);
    assign w_lock_lost   = !w_lock_s && ((r_state == c_st_enable) || (r_state == c_st_run));
    assign w_restart_run = restart_req && (r_state == c_st_run);
    assign w_teardown    = w_lock_lost || w_restart_run;

    // Enable i rises when the ENABLE-state cycle count reaches i*EN_GAP;
    // enable 0 is set on entry to ENABLE.
    assign w_en_set[0] = 1'b0;
    for (genvar gi = 1; gi < NUM_CLK; gi++) begin : g_en_step
        localparam logic [c_cnt_w-1:0] c_step = c_cnt_w'(gi * EN_GAP);
        assign w_en_set[gi] = (w_cnt_inc == c_step);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_st_reset_pll;
            r_cnt       <= '0;
            r_filt      <= '0;
            r_retry     <= '0;
            r_unlock    <= '0;
            r_pll_reset <= 1'b1;
            r_enclk     <= '0;
            r_sys_rst_n <= 1'b0;
            r_ready     <= 1'b0;
            r_fault     <= 1'b0;
        end else if (w_teardown) begin
            r_state     <= c_st_reset_pll;
            r_cnt       <= '0;
            r_pll_reset <= 1'b1;
            r_enclk     <= '0;
            r_sys_rst_n <= 1'b0;
            r_ready     <= 1'b0;
            if (w_lock_lost && (r_unlock != c_unlock_max)) begin
                r_unlock <= r_unlock + c_unlock_one;
            end
            if (w_restart_run) begin
                r_retry <= '0;
            end
        end else begin
            case (r_state)
                c_st_reset_pll: begin
                    if (r_cnt == c_rst_last) begin
                        r_state     <= c_st_wait_lock;
                        r_cnt       <= '0;
                        r_filt      <= '0;
                        r_pll_reset <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end

                c_st_wait_lock: begin
                    if (w_filt_done) begin
                        r_state <= c_st_enable;
                        r_cnt   <= '0;
                        r_enclk <= c_enclk_first;
                    end else if (w_tmo_done) begin
                        r_cnt       <= '0;
                        r_retry     <= w_retry_inc;
                        r_pll_reset <= 1'b1;
                        if (w_retry_inc == c_retry_limit) begin
                            r_state <= c_st_fault;
                            r_fault <= 1'b1;
                        end else begin
                            r_state <= c_st_reset_pll;
                        end
                    end else begin
                        r_cnt  <= w_cnt_inc;
                        r_filt <= w_lock_s ? w_filt_inc : '0;
                    end
                end

                c_st_enable: begin
                    if (r_cnt == c_en_last) begin
                        r_state     <= c_st_run;
                        r_cnt       <= '0;
                        r_retry     <= '0;
                        r_sys_rst_n <= 1'b1;
                        r_ready     <= 1'b1;
                    end else begin
                        r_cnt   <= w_cnt_inc;
                        r_enclk <= r_enclk | w_en_set;
                    end
                end

                c_st_run: begin
                    r_state <= c_st_run;
                end

                c_st_fault: begin
                    if (restart_req) begin
                        r_state <= c_st_reset_pll;
                        r_cnt   <= '0;
                        r_retry <= '0;
                        r_fault <= 1'b0;
                    end
                end

                default: begin
                    r_state     <= c_st_reset_pll;
                    r_cnt       <= '0;
                    r_filt      <= '0;
                    r_pll_reset <= 1'b1;
                    r_enclk     <= '0;
                    r_sys_rst_n <= 1'b0;
                    r_ready     <= 1'b0;
                    r_fault     <= 1'b0;
                end
            endcase
        end
    end

    assign pll_reset  = r_pll_reset;
    assign pll_enclk  = r_enclk;
    assign sys_rst_n  = r_sys_rst_n;
    assign ready      = r_ready;
    assign fault      = r_fault;
    assign unlock_cnt = r_unlock;

endmodule
`default_nettype wire
